// File: rtl/uart_fast_pkg.sv
// uart_fast_pkg
//   Types and constants shared by the uart_fast receive and transmit paths.
//   - rx_state_t        : receiver state encoding
//   - DEF_CLKS_PER_BIT  : default clocks per bit (50 MHz / 115200)
//   - DEF_DATA_BITS     : default data bits per frame
//   - clog2()           : ceiling log2, usable in localparam expressions
package uart_fast_pkg;

   localparam int DEF_CLKS_PER_BIT = 434;
   localparam int DEF_DATA_BITS    = 8;

   typedef enum logic [2:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_PARITY,
      RX_STOP,
      RX_RECOVER
   } rx_state_t;

   function automatic int clog2(input int value);
      int w = 0;
      while ((1 << w) < value) w++;
      return w;
   endfunction

endpackage

// File: rtl/uart_fast_rx_fifo.sv
// uart_fast_rx_fifo
//   Synchronous show-ahead FIFO; the head entry is always visible on 'head'.
//   A push while full is accepted only if a pop happens in the same cycle.
//   Storage is cleared on reset so the head reads 0 while empty after reset.
// Ports:
//   clk, reset_n        clock, async active-low reset
//   push, push_data     write request and data
//   pop                 read request (ignored while empty)
//   head                current head entry
//   full, empty         occupancy flags
module uart_fast_rx_fifo
   import uart_fast_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty
);

   localparam int AW = clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign full    = (count == (AW+1)'(DEPTH));
   assign do_pop  = pop && !empty;
   // A full FIFO still takes the new entry when the head leaves in the same cycle.
   assign do_push = push && (!full || do_pop);
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (do_pop) rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/uart_fast_rx.sv
// uart_fast_rx
//   UART receiver: 2-flop synchronizer, mid-bit sampling FSM, LSB-first
//   shift register, stop-bit check and a show-ahead receive FIFO.
//   Optional even parity is enabled by defining UART_FAST_RX_PARITY_EN.
// Ports:
//   clk, reset_n   system clock, async active-low reset
//   uart_rx        serial line (idle high, asynchronous)
//   rd_data        FIFO head byte
//   rd_valid       FIFO non-empty
//   rd_ready       consumer accepts rd_data when rd_valid
//   frame_err      one-cycle pulse, stop bit sampled low
//   overrun        one-cycle pulse, good byte dropped because FIFO full
//   busy           receiver not idle
//   parity_err     (UART_FAST_RX_PARITY_EN only) one-cycle pulse, parity mismatch
//
// state      | meaning
// -----------+-------------------------------------------------------------
// RX_IDLE    | line idle, waiting for a falling edge on rxs
// RX_START   | half-bit wait, confirm start bit still low (glitch reject)
// RX_DATA    | sample one data bit per bit time, shift in at the MSB
// RX_PARITY  | sample the even-parity bit (parity build only)
// RX_STOP    | sample the stop bit, push byte or flag framing error
// RX_RECOVER | after a framing error, wait for the line to return high
module uart_fast_rx
   import uart_fast_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
   parameter int DATA_BITS    = DEF_DATA_BITS,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 uart_rx,
   output logic [DATA_BITS-1:0] rd_data,
   output logic                 rd_valid,
   input  logic                 rd_ready,
   output logic                 frame_err,
   output logic                 overrun,
   output logic                 busy
`ifdef UART_FAST_RX_PARITY_EN
   ,
   output logic                 parity_err
`endif
);

   localparam int CW = clog2(CLKS_PER_BIT);
   localparam int IW = clog2(DATA_BITS);
   localparam logic [CW-1:0] HALF_TC  = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] FULL_TC  = CW'(CLKS_PER_BIT - 1);
   localparam logic [IW-1:0] LAST_BIT = IW'(DATA_BITS - 1);

   logic                 rx_meta;
   logic                 rxs;
   rx_state_t            state, state_nx;
   logic [CW-1:0]        cnt, cnt_nx;
   logic [IW-1:0]        bit_idx, bit_idx_nx;
   logic [DATA_BITS-1:0] shreg, shreg_nx;
   logic                 tc;
   logic                 push;
   logic                 frame_err_nx;
   logic                 fifo_full;
   logic                 fifo_empty;
`ifdef UART_FAST_RX_PARITY_EN
   logic                 par_bit, par_bit_nx;
   logic                 parity_err_nx;
`endif

   // Sync flops reset to 1 so a line held low through reset cannot start a frame.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rx_meta <= 1'b1;
         rxs     <= 1'b1;
      end else begin
         rx_meta <= uart_rx;
         rxs     <= rx_meta;
      end
   end

   assign tc = (cnt == '0);

   always_comb begin
      state_nx     = state;
      cnt_nx       = tc ? cnt : cnt - 1'b1;
      bit_idx_nx   = bit_idx;
      shreg_nx     = shreg;
      push         = 1'b0;
      frame_err_nx = 1'b0;
`ifdef UART_FAST_RX_PARITY_EN
      par_bit_nx    = par_bit;
      parity_err_nx = 1'b0;
`endif
      case (state)
         RX_IDLE: begin
            if (!rxs) begin
               state_nx = RX_START;
               cnt_nx   = HALF_TC;
            end
         end
         RX_START: begin
            if (tc) begin
               if (!rxs) begin
                  state_nx   = RX_DATA;
                  cnt_nx     = FULL_TC;
                  bit_idx_nx = '0;
               end else begin
                  state_nx = RX_IDLE;
               end
            end
         end
         RX_DATA: begin
            if (tc) begin
               shreg_nx   = {rxs, shreg[DATA_BITS-1:1]};
               bit_idx_nx = bit_idx + 1'b1;
               cnt_nx     = FULL_TC;
               if (bit_idx == LAST_BIT) begin
`ifdef UART_FAST_RX_PARITY_EN
                  state_nx = RX_PARITY;
`else
                  state_nx = RX_STOP;
`endif
               end
            end
         end
`ifdef UART_FAST_RX_PARITY_EN
         RX_PARITY: begin
            if (tc) begin
               par_bit_nx = rxs;
               cnt_nx     = FULL_TC;
               state_nx   = RX_STOP;
            end
         end
`endif
         RX_STOP: begin
            if (tc) begin
               if (rxs) begin
                  // Leave at mid stop bit so a back-to-back start edge is not missed.
                  state_nx = RX_IDLE;
`ifdef UART_FAST_RX_PARITY_EN
                  if ((^shreg) == par_bit) push = 1'b1;
                  else                     parity_err_nx = 1'b1;
`else
                  push = 1'b1;
`endif
               end else begin
                  frame_err_nx = 1'b1;
                  state_nx     = RX_RECOVER;
               end
            end
         end
         RX_RECOVER: begin
            if (rxs) state_nx = RX_IDLE;
         end
         default: state_nx = RX_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= RX_IDLE;
         cnt       <= '0;
         bit_idx   <= '0;
         shreg     <= '0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
`ifdef UART_FAST_RX_PARITY_EN
         par_bit    <= 1'b0;
         parity_err <= 1'b0;
`endif
      end else begin
         state     <= state_nx;
         cnt       <= cnt_nx;
         bit_idx   <= bit_idx_nx;
         shreg     <= shreg_nx;
         frame_err <= frame_err_nx;
         // A simultaneous pop frees the slot, so that case is not an overrun.
         overrun   <= push && fifo_full && !(rd_ready && !fifo_empty);
`ifdef UART_FAST_RX_PARITY_EN
         par_bit    <= par_bit_nx;
         parity_err <= parity_err_nx;
`endif
      end
   end

   uart_fast_rx_fifo #(
      .WIDTH (DATA_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset_n   (reset_n),
      .push      (push),
      .push_data (shreg),
      .pop       (rd_ready),
      .head      (rd_data),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   assign rd_valid = !fifo_empty;
   assign busy     = (state != RX_IDLE);

endmodule

// File: tb/tb_uart_fast_rx.sv
// Scoreboard bench for uart_fast_rx: frames are driven bit by bit, the
// reference model decides per frame whether the byte lands in the FIFO,
// is dropped (overrun) or flagged (framing error); a monitor process
// compares every DUT read and counts error pulses.
module tb_uart_fast_rx;

   localparam int CPB   = 16;
   localparam int DEPTH = 4;

   logic       clk      = 1'b0;
   logic       reset_n  = 1'b0;
   logic       uart_rx  = 1'b1;
   logic       rd_ready = 1'b0;
   logic [7:0] rd_data;
   logic       rd_valid;
   logic       frame_err;
   logic       overrun;
   logic       busy;

   int tests = 0;
   int fails = 0;

   logic [7:0] exp_q[$];
   int exp_ferr  = 0;
   int exp_ovr   = 0;
   int ferr_seen = 0;
   int ovr_seen  = 0;

   uart_fast_rx #(
      .CLKS_PER_BIT (CPB),
      .DATA_BITS    (8),
      .FIFO_DEPTH   (DEPTH)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .uart_rx   (uart_rx),
      .rd_data   (rd_data),
      .rd_valid  (rd_valid),
      .rd_ready  (rd_ready),
      .frame_err (frame_err),
      .overrun   (overrun),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: every accepted read must match the oldest byte the model expects.
   always @(negedge clk) begin
      if (reset_n) begin
         if (frame_err) ferr_seen++;
         if (overrun)   ovr_seen++;
         if (rd_valid && rd_ready) begin
            if (exp_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_byte: got 0x%0h, expected no byte", rd_data);
            end else begin
               check("rd_data", int'(rd_data), int'(exp_q.pop_front()));
            end
         end
      end
   end

   // Reference model: a good frame occupies a slot unless the FIFO already
   // holds DEPTH bytes and nothing is read in the push cycle.
   task automatic model_push(input logic [7:0] b, input bit pop_at_push);
      if (exp_q.size() >= DEPTH && !pop_at_push) exp_ovr++;
      else exp_q.push_back(b);
   endtask

   // All drivers run at posedge+1.
   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic drive_bit(input logic v);
      uart_rx = v;
      idle(CPB);
   endtask

   // Leaves the line at the stop-bit level. With ready_at_push, rd_ready rises
   // for exactly the stop-bit sample cycle (2 sync + 1 detect + 8 half + 9*16).
   task automatic send_frame(input logic [7:0] b, input logic stop, input bit ready_at_push);
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(b[i]);
      if (stop) model_push(b, ready_at_push);
      else      exp_ferr++;
      uart_rx = stop;
      if (ready_at_push) begin
         idle(CPB - 6);
         rd_ready = 1'b1;
         idle(6);
      end else begin
         idle(CPB);
      end
   endtask

   task automatic wait_drain(input string name);
      int n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         @(posedge clk);
         #1;
         n++;
      end
      check(name, exp_q.size(), 0);
   endtask

   task automatic check_counts(input string tag);
      check({tag, "_frame_err_count"}, ferr_seen, exp_ferr);
      check({tag, "_overrun_count"}, ovr_seen, exp_ovr);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      bit saw_busy;
      bit busy_dropped;
      int n;
      logic [7:0] b;
      logic stop;

      reset_n = 1'b0;
      idle(3);
      reset_n = 1'b1;
      @(negedge clk);
      check("reset_rd_valid", rd_valid, 0);
      check("reset_rd_data", rd_data, 0);
      check("reset_frame_err", frame_err, 0);
      check("reset_overrun", overrun, 0);
      check("reset_busy", busy, 0);
      @(posedge clk);
      #1;

      // Single good frame.
      rd_ready = 1'b1;
      send_frame(8'hA5, 1'b1, 1'b0);
      idle(20);
      wait_drain("a5_delivered");
      check_counts("a5");

      // Short low glitch: START must reject it.
      saw_busy = 1'b0;
      uart_rx  = 1'b0;
      repeat (5) begin
         @(negedge clk);
         if (busy) saw_busy = 1'b1;
      end
      @(posedge clk);
      #1;
      uart_rx = 1'b1;
      n = 0;
      while (busy && n < 12) begin
         @(negedge clk);
         n++;
      end
      check("glitch_busy_seen", saw_busy, 1);
      check("glitch_busy_clear", busy, 0);
      check("glitch_clear_within_10", int'(n <= 10), 1);
      @(posedge clk);
      #1;
      idle(10);

      // Framing error followed by a long break, then a good frame.
      send_frame(8'h3C, 1'b0, 1'b0);
      busy_dropped = 1'b0;
      repeat (40) begin
         repeat (CPB) @(negedge clk);
         if (!busy) busy_dropped = 1'b1;
      end
      check("break_busy_dropped", busy_dropped, 0);
      check("break_frame_err_count", ferr_seen, 1);
      @(posedge clk);
      #1;
      uart_rx = 1'b1;
      idle(8);
      send_frame(8'h55, 1'b1, 1'b0);
      idle(20);
      wait_drain("break_55_delivered");
      check_counts("break");

      // Overrun: five back-to-back frames with no reads.
      rd_ready = 1'b0;
      for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, 1'b0);
      idle(20);
      check("overrun_count", ovr_seen, 1);
      check("full_rd_valid", rd_valid, 1);
      rd_ready = 1'b1;
      wait_drain("overrun_drain");
      idle(2);
      @(negedge clk);
      check("drained_rd_valid", rd_valid, 0);
      @(posedge clk);
      #1;

      // Full FIFO with a read exactly in the push cycle: no overrun.
      rd_ready = 1'b0;
      for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b1, 1'b0);
      send_frame(8'h06, 1'b1, 1'b1);
      idle(20);
      wait_drain("push_pop_full_drain");
      check_counts("push_pop_full");

      // Reset during data bit 3 clears the partial byte and the FIFO.
      rd_ready = 1'b0;
      send_frame(8'h11, 1'b1, 1'b0);
      idle(5);
      b = 8'h7E;
      drive_bit(1'b0);
      for (int i = 0; i < 3; i++) drive_bit(b[i]);
      uart_rx = b[3];
      idle(CPB / 2);
      reset_n = 1'b0;
      exp_q.delete();
      @(negedge clk);
      check("midreset_rd_valid", rd_valid, 0);
      check("midreset_rd_data", rd_data, 0);
      check("midreset_busy", busy, 0);
      check("midreset_frame_err", frame_err, 0);
      check("midreset_overrun", overrun, 0);
      @(posedge clk);
      #1;
      uart_rx = 1'b1;
      idle(3);
      reset_n = 1'b1;
      idle(5);
      rd_ready = 1'b1;
      send_frame(8'h81, 1'b1, 1'b0);
      idle(20);
      wait_drain("post_reset_81");
      check_counts("post_reset");

      // Random frames, occasional bad stop bits, random gaps.
      for (int k = 0; k < 16; k++) begin
         b    = 8'($urandom_range(0, 255));
         stop = ($urandom_range(0, 5) != 0);
         send_frame(b, stop, 1'b0);
         if (!stop) begin
            uart_rx = 1'b1;
            idle($urandom_range(4, 20));
         end else begin
            idle($urandom_range(0, 12));
         end
      end
      idle(20);
      wait_drain("random_drain");
      check_counts("random");
      @(negedge clk);
      check("final_busy", busy, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
